// File: rtl/dcache_arb_pkg.sv
// Shared types for the data-cache request arbiter.
// Requester ids, grant states and the request beat bundle.
package dcache_arb_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_CPU,
    LOCK_DMA
  } arb_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic        burst;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } beat_t;

  function automatic arb_state_t lock_of(req_id_t id);
    return (id == REQ_CPU) ? LOCK_CPU : LOCK_DMA;
  endfunction

endpackage

// File: rtl/dcache_arb_tagfifo.sv
// Requester-id FIFO for reads in flight.
// Power-of-two depth, 1-bit payload, async active-low reset.
module dcache_arb_tagfifo #(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0] slots;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dcache_arbiter.sv
// CPU/DMA round-robin arbiter for the data-cache request bus.
// Burst lock, in-order read steering via a tag FIFO.
module dcache_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_request,
  output logic        cpu_ready,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic        cpu_burst,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_request,
  output logic        dma_ready,
  input  logic        dma_write,
  input  logic [31:0] dma_address,
  input  logic        dma_burst,
  input  logic [3:0]  dma_wstrb,
  input  logic [31:0] dma_wdata,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_request,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic        mem_burst,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        error_unexpected_resp
);

  arb_state_t state_q, state_d;
  req_id_t    last_q, last_d;
  req_id_t    gnt_id;
  logic       gnt_valid;
  logic       gnt_req;
  beat_t      cpu_beat, dma_beat, gnt_beat, out_beat;
  logic       read_block;
  logic       accept;
  logic       fifo_full, fifo_empty, fifo_head;
  logic       tag_pop;
  logic       err_q;

  assign cpu_beat = '{cpu_write, cpu_address, cpu_burst,
                      cpu_wstrb, cpu_wdata};
  assign dma_beat = '{dma_write, dma_address, dma_burst,
                      dma_wstrb, dma_wdata};

  // IDLE grants combinationally; a tie goes to whoever did not win last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = REQ_CPU;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          cpu_request && dma_request: begin
            gnt_valid = 1'b1;
            gnt_id    = (last_q == REQ_DMA) ? REQ_CPU : REQ_DMA;
          end
          cpu_request && !dma_request: begin
            gnt_valid = 1'b1;
            gnt_id    = REQ_CPU;
          end
          !cpu_request && dma_request: begin
            gnt_valid = 1'b1;
            gnt_id    = REQ_DMA;
          end
          default: ;
        endcase
      end
      LOCK_CPU: begin
        gnt_valid = 1'b1;
        gnt_id    = REQ_CPU;
      end
      LOCK_DMA: begin
        gnt_valid = 1'b1;
        gnt_id    = REQ_DMA;
      end
      default: ;
    endcase
  end

  assign gnt_beat = (gnt_id == REQ_CPU) ? cpu_beat : dma_beat;
  assign gnt_req  = (gnt_id == REQ_CPU) ? cpu_request : dma_request;

  assign read_block = gnt_valid & ~gnt_beat.write & fifo_full;

  // Outputs are forced low while reset is held.
  assign out_beat    = (reset && gnt_valid) ? gnt_beat : '0;
  assign mem_request = reset & gnt_valid & gnt_req & ~read_block;
  assign mem_write   = out_beat.write;
  assign mem_address = out_beat.address;
  assign mem_burst   = out_beat.burst;
  assign mem_wstrb   = out_beat.wstrb;
  assign mem_wdata   = out_beat.wdata;

  assign cpu_ready = reset & gnt_valid & (gnt_id == REQ_CPU)
                   & mem_ready & ~read_block;
  assign dma_ready = reset & gnt_valid & (gnt_id == REQ_DMA)
                   & mem_ready & ~read_block;

  assign accept = mem_request & mem_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (accept) begin
      if (gnt_beat.burst) begin
        state_d = lock_of(gnt_id);
      end else begin
        state_d = IDLE;
        last_d  = gnt_id;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= REQ_DMA;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (mem_rvalid && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign tag_pop = mem_rvalid & ~fifo_empty;

  dcache_arb_tagfifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tagfifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept & ~gnt_beat.write),
    .push_data (gnt_id),
    .pop       (tag_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign cpu_rvalid = reset & tag_pop & (req_id_t'(fifo_head) == REQ_CPU);
  assign dma_rvalid = reset & tag_pop & (req_id_t'(fifo_head) == REQ_DMA);
  assign cpu_rdata  = reset ? mem_rdata : '0;
  assign dma_rdata  = reset ? mem_rdata : '0;

  assign error_unexpected_resp = err_q;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Scenario bench for dcache_arbiter with a response scoreboard.
// Expected read responses are queued at acceptance and checked on return.
module tb_dcache_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_request, cpu_ready, cpu_write, cpu_burst;
  logic [31:0] cpu_address, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_rvalid;
  logic        dma_request, dma_ready, dma_write, dma_burst;
  logic [31:0] dma_address, dma_wdata, dma_rdata;
  logic [3:0]  dma_wstrb;
  logic        dma_rvalid;
  logic        mem_request, mem_write, mem_burst;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_rvalid;
  logic        error_unexpected_resp;

  typedef struct {
    logic        is_dma;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   seq      = 0;

  always #5 clock = ~clock;

  dcache_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .cpu_request           (cpu_request),
    .cpu_ready             (cpu_ready),
    .cpu_write             (cpu_write),
    .cpu_address           (cpu_address),
    .cpu_burst             (cpu_burst),
    .cpu_wstrb             (cpu_wstrb),
    .cpu_wdata             (cpu_wdata),
    .cpu_rvalid            (cpu_rvalid),
    .cpu_rdata             (cpu_rdata),
    .dma_request           (dma_request),
    .dma_ready             (dma_ready),
    .dma_write             (dma_write),
    .dma_address           (dma_address),
    .dma_burst             (dma_burst),
    .dma_wstrb             (dma_wstrb),
    .dma_wdata             (dma_wdata),
    .dma_rvalid            (dma_rvalid),
    .dma_rdata             (dma_rdata),
    .mem_request           (mem_request),
    .mem_write             (mem_write),
    .mem_address           (mem_address),
    .mem_burst             (mem_burst),
    .mem_wstrb             (mem_wstrb),
    .mem_wdata             (mem_wdata),
    .mem_ready             (mem_ready),
    .mem_rvalid            (mem_rvalid),
    .mem_rdata             (mem_rdata),
    .error_unexpected_resp (error_unexpected_resp)
  );

  task automatic idle_inputs();
    cpu_request = 1'b0; cpu_write = 1'b0; cpu_burst = 1'b0;
    cpu_address = '0;   cpu_wstrb = '0;   cpu_wdata = '0;
    dma_request = 1'b0; dma_write = 1'b0; dma_burst = 1'b0;
    dma_address = '0;   dma_wstrb = '0;   dma_wdata = '0;
    mem_ready   = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic drive_cpu(input logic wr, input logic [31:0] a,
                           input logic b);
    cpu_request = 1'b1; cpu_write = wr; cpu_address = a;
    cpu_burst = b; cpu_wstrb = 4'hf; cpu_wdata = a ^ 32'h5a5a_5a5a;
  endtask

  task automatic drive_dma(input logic wr, input logic [31:0] a,
                           input logic b);
    dma_request = 1'b1; dma_write = wr; dma_address = a;
    dma_burst = b; dma_wstrb = 4'h3; dma_wdata = a ^ 32'hc3c3_c3c3;
  endtask

  task automatic push_exp(input logic is_dma, input logic [31:0] d);
    exp_t e;
    e.is_dma = is_dma;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    drive_cpu(1'b0, 32'h1234, 1'b0);
    drive_dma(1'b1, 32'h5678, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'hffff_ffff;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if ({mem_request, cpu_ready, dma_ready, cpu_rvalid, dma_rvalid,
         error_unexpected_resp} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b want=000000",
        {mem_request, cpu_ready, dma_ready, cpu_rvalid, dma_rvalid,
         error_unexpected_resp});
    end
    n_checks++;
    if (mem_address !== 32'h0 || cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got addr=%h rdata=%h want 0 0",
        mem_address, cpu_rdata);
    end
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_request, cpu_ready, dma_ready, cpu_rvalid, dma_rvalid,
         error_unexpected_resp, mem_address} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_outputs got nonzero want 0");
    end
  endtask

  task automatic test_tie();
    @(negedge clock);
    idle_inputs();
    drive_cpu(1'b0, 32'h100, 1'b0);
    drive_dma(1'b0, 32'h200, 1'b0);
    #1;
    n_checks++;
    if (cpu_ready !== 1'b1 || dma_ready !== 1'b0 ||
        mem_address !== 32'h100 || mem_request !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_cycle0 got c=%b d=%b a=%h want 1 0 100",
        cpu_ready, dma_ready, mem_address);
    end
    push_exp(1'b0, 32'h1111_1111);
    @(negedge clock);
    idle_inputs();
    drive_dma(1'b0, 32'h200, 1'b0);
    #1;
    n_checks++;
    if (dma_ready !== 1'b1 || cpu_ready !== 1'b0 ||
        mem_address !== 32'h200) begin
      n_fail++;
      $display("FAIL tie_cycle1 got c=%b d=%b a=%h want 0 1 200",
        cpu_ready, dma_ready, mem_address);
    end
    push_exp(1'b1, 32'h2222_2222);
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_responses();
    int budget;
    exp_t e;
    budget = 32;
    while (sb.size() > 0 && budget > 0) begin
      budget--;
      @(negedge clock);
      idle_inputs();
      e = sb.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = e.data;
      #1;
      n_checks++;
      if (cpu_rvalid !== !e.is_dma || dma_rvalid !== e.is_dma) begin
        n_fail++;
        $display("FAIL resp_steer got c=%b d=%b want c=%b d=%b",
          cpu_rvalid, dma_rvalid, !e.is_dma, e.is_dma);
      end
      n_checks++;
      if ((e.is_dma ? dma_rdata : cpu_rdata) !== e.data) begin
        n_fail++;
        $display("FAIL resp_data got=%h want=%h",
          e.is_dma ? dma_rdata : cpu_rdata, e.data);
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL resp_budget got left=%0d want 0", sb.size());
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_burst_lock();
    @(negedge clock);
    idle_inputs();
    drive_dma(1'b1, 32'h1000, 1'b1);
    #1;
    n_checks++;
    if (dma_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_beat0 got=%b want=1", dma_ready);
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clock);
      idle_inputs();
      drive_dma(1'b1, 32'h1000 + 32'(4 * i), (i < 3));
      drive_cpu(1'b1, 32'h3000, 1'b0);
      #1;
      n_checks++;
      if (dma_ready !== 1'b1 || cpu_ready !== 1'b0 ||
          mem_address !== 32'h1000 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL burst_beat%0d got d=%b c=%b a=%h want 1 0 %h",
          i, dma_ready, cpu_ready, mem_address, 32'h1000 + 32'(4 * i));
      end
    end
    @(negedge clock);
    idle_inputs();
    drive_cpu(1'b1, 32'h3000, 1'b0);
    drive_dma(1'b1, 32'h2000, 1'b0);
    #1;
    n_checks++;
    if (cpu_ready !== 1'b1 || dma_ready !== 1'b0 ||
        mem_address !== 32'h3000) begin
      n_fail++;
      $display("FAIL burst_after_tie got c=%b d=%b a=%h want 1 0 3000",
        cpu_ready, dma_ready, mem_address);
    end
    @(negedge clock);
    idle_inputs();
    drive_dma(1'b1, 32'h2000, 1'b0);
    #1;
    n_checks++;
    if (dma_ready !== 1'b1 || mem_wstrb !== 4'h3) begin
      n_fail++;
      $display("FAIL burst_dma_next got d=%b s=%h want 1 3",
        dma_ready, mem_wstrb);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      idle_inputs();
      mem_ready = 1'b0;
      drive_cpu(1'b0, 32'h400, 1'b0);
      drive_dma(1'b1, 32'h500, 1'b0);
      #1;
      n_checks++;
      if (cpu_ready !== 1'b0 || dma_ready !== 1'b0 ||
          mem_request !== 1'b1 || mem_address !== 32'h400) begin
        n_fail++;
        $display("FAIL bp_hold%0d got c=%b d=%b r=%b a=%h want 0 0 1 400",
          i, cpu_ready, dma_ready, mem_request, mem_address);
      end
    end
    @(negedge clock);
    idle_inputs();
    drive_cpu(1'b0, 32'h400, 1'b0);
    drive_dma(1'b1, 32'h500, 1'b0);
    #1;
    n_checks++;
    if (cpu_ready !== 1'b1 || mem_address !== 32'h400) begin
      n_fail++;
      $display("FAIL bp_release got c=%b a=%h want 1 400",
        cpu_ready, mem_address);
    end
    seq++;
    push_exp(1'b0, 32'hb000_0000 + 32'(seq));
    @(negedge clock);
    idle_inputs();
    drive_dma(1'b1, 32'h500, 1'b0);
    #1;
    n_checks++;
    if (dma_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_dma_after got=%b want=1", dma_ready);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_full_fifo();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      idle_inputs();
      drive_cpu(1'b0, 32'h600 + 32'(4 * i), 1'b0);
      #1;
      n_checks++;
      if (cpu_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL full_fill%0d got=%b want=1", i, cpu_ready);
      end
      seq++;
      push_exp(1'b0, 32'hc000_0000 + 32'(seq));
    end
    @(negedge clock);
    idle_inputs();
    drive_cpu(1'b0, 32'h700, 1'b0);
    #1;
    n_checks++;
    if (mem_request !== 1'b0 || cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_block got r=%b c=%b want 0 0",
        mem_request, cpu_ready);
    end
    @(negedge clock);
    idle_inputs();
    drive_cpu(1'b0, 32'h700, 1'b0);
    drive_dma(1'b1, 32'h800, 1'b0);
    #1;
    n_checks++;
    if (dma_ready !== 1'b1 || mem_request !== 1'b1 ||
        mem_write !== 1'b1 || cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_dma_write got d=%b r=%b w=%b c=%b want 1 1 1 0",
        dma_ready, mem_request, mem_write, cpu_ready);
    end
    @(negedge clock);
    idle_inputs();
    drive_cpu(1'b0, 32'h700, 1'b0);
    e = sb.pop_front();
    mem_rvalid = 1'b1;
    mem_rdata  = e.data;
    #1;
    n_checks++;
    if (cpu_ready !== 1'b0 || cpu_rvalid !== 1'b1 ||
        cpu_rdata !== e.data) begin
      n_fail++;
      $display("FAIL full_pop got c=%b v=%b d=%h want 0 1 %h",
        cpu_ready, cpu_rvalid, cpu_rdata, e.data);
    end
    @(negedge clock);
    idle_inputs();
    drive_cpu(1'b0, 32'h700, 1'b0);
    #1;
    n_checks++;
    if (cpu_ready !== 1'b1 || mem_address !== 32'h700) begin
      n_fail++;
      $display("FAIL full_retry got c=%b a=%h want 1 700",
        cpu_ready, mem_address);
    end
    seq++;
    push_exp(1'b0, 32'hc000_0000 + 32'(seq));
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_unexpected();
    @(negedge clock);
    idle_inputs();
    #1;
    n_checks++;
    if (error_unexpected_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL unexp_pre got=%b want=0", error_unexpected_resp);
    end
    @(negedge clock);
    idle_inputs();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hdead_beef;
    #1;
    n_checks++;
    if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL unexp_rvalid got c=%b d=%b want 0 0",
        cpu_rvalid, dma_rvalid);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    n_checks++;
    if (error_unexpected_resp !== 1'b1) begin
      n_fail++;
      $display("FAIL unexp_set got=%b want=1", error_unexpected_resp);
    end
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (error_unexpected_resp !== 1'b1) begin
      n_fail++;
      $display("FAIL unexp_sticky got=%b want=1", error_unexpected_resp);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    idle_inputs();
    drive_cpu(1'b0, 32'h900, 1'b0);
    @(negedge clock);
    idle_inputs();
    drive_cpu(1'b0, 32'h904, 1'b0);
    @(negedge clock);
    idle_inputs();
    drive_dma(1'b1, 32'ha00, 1'b1);
    #1;
    n_checks++;
    if (dma_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_burst_start got=%b want=1", dma_ready);
    end
    @(negedge clock);
    idle_inputs();
    drive_dma(1'b1, 32'ha04, 1'b1);
    drive_cpu(1'b0, 32'h908, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    #1;
    n_checks++;
    if (dma_ready !== 1'b1 || cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_locked got d=%b c=%b want 1 0",
        dma_ready, cpu_ready);
    end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_request, cpu_ready, dma_ready, cpu_rvalid, dma_rvalid,
         error_unexpected_resp} !== 6'b0 || mem_address !== 32'h0 ||
        cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got r=%b c=%b d=%b e=%b a=%h want 0",
        mem_request, cpu_ready, dma_ready, error_unexpected_resp,
        mem_address);
    end
    sb.delete();
    @(negedge clock);
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    drive_cpu(1'b1, 32'hb00, 1'b0);
    drive_dma(1'b1, 32'hb04, 1'b0);
    #1;
    n_checks++;
    if (cpu_ready !== 1'b1 || dma_ready !== 1'b0 ||
        error_unexpected_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after_tie got c=%b d=%b e=%b want 1 0 0",
        cpu_ready, dma_ready, error_unexpected_resp);
    end
    @(negedge clock);
    idle_inputs();
    mem_rvalid = 1'b1;
    #1;
    n_checks++;
    if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_tags_gone got c=%b d=%b want 0 0",
        cpu_rvalid, dma_rvalid);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    n_checks++;
    if (error_unexpected_resp !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_error got=%b want=1", error_unexpected_resp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_tie();
    test_responses();
    test_burst_lock();
    test_backpressure();
    test_responses();
    test_full_fifo();
    test_responses();
    test_unexpected();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
